dram_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single `dram_interface` block bus between the instruction-cache and data-cache miss handlers. It accepts whole-block read or write requests from each requester, grants one at a time with round-robin fairness, and drives the `dram_interface` bus ports. It forwards the returned block and routes the memory acknowledge back to the granted requester only. It sits between the cache controllers and `dram_interface` in the CPU top level.

---
 rtl/dram_bus_arbiter_pkg.sv | 30 +++
 rtl/dram_bus_arbiter.sv | 110 +++++++++++
 tb/tb_dram_bus_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dram_bus_arbiter_pkg.sv
// Shared constants and types for the DRAM bus arbiter.
// Width macros normally come from config.sv; the defaults below are used only when it is absent.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif

package dram_bus_arbiter_pkg;

    localparam int ADDR_W      = `DRAM_ADDRESS_SIZE;
    localparam int WORD_W      = `DRAM_WORD_SIZE;
    localparam int BLOCK_WORDS = `DRAM_BLOCK_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_op_t;

endpackage

// File: rtl/dram_bus_arbiter.sv
// Round-robin arbiter sharing the dram_interface block bus between icache (0) and dcache (1).
// Each transaction walks IDLE -> BUSY -> ACK; a just-acked requester is masked for one IDLE cycle.
module dram_bus_arbiter
    import dram_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]                 req_address,
    input  logic [NUM_REQ-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] req_data_to_mem,
    input  logic [NUM_REQ-1:0]                             req_read_enable,
    input  logic [NUM_REQ-1:0]                             req_write_enable,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]             req_data_from_mem,
    output logic [NUM_REQ-1:0]                             req_acknowledge,
    output logic [ADDR_W-1:0]                              bus_address_to_mem,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]             bus_data_to_mem,
    output logic                                           bus_read_enable,
    output logic                                           bus_write_enable,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]             bus_data_from_mem,
    input  logic                                           acknowledge_from_mem,
    output logic                                           grant_valid,
    output logic                                           grant_id
);

    arb_state_t          state_reg;
    arb_state_t          state_next;
    mem_op_t             op_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                grant_id_reg;
    logic                last_grant_reg;
    logic                ignore_valid_reg;
    logic [NUM_REQ-1:0]  ignore_mask;
    logic [NUM_REQ-1:0]  pending;
    logic                winner;

    // Two-way round-robin: the requester after the last grant gets first refusal.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic first;
        first = ~last;
        return req[first] ? first : last;
    endfunction

    assign ignore_mask = ignore_valid_reg ? (NUM_REQ'(1) << last_grant_reg) : '0;
    assign pending     = (req_read_enable | req_write_enable) & ~ignore_mask;
    assign winner      = rr_pick(pending, last_grant_reg);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|pending)            state_next = BUSY;
            BUSY:    if (acknowledge_from_mem) state_next = ACK;
            ACK:                               state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Grant bookkeeping; ignore_valid_reg is high only in the IDLE cycle that follows ACK.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_reg           <= READ;
            addr_reg         <= '0;
            grant_id_reg     <= 1'b0;
            last_grant_reg   <= 1'b1;
            ignore_valid_reg <= 1'b0;
        end else begin
            ignore_valid_reg <= (state_reg == ACK);
            if (state_reg == IDLE && (|pending)) begin
                grant_id_reg <= winner;
                addr_reg     <= req_address[winner];
                op_reg       <= req_write_enable[winner] ? WRITE : READ;
            end
            if (state_reg == ACK) begin
                last_grant_reg <= grant_id_reg;
            end
        end
    end

    always_comb begin
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        req_acknowledge  = '0;
        grant_valid      = 1'b0;
        case (state_reg)
            BUSY: begin
                bus_read_enable  = (op_reg == READ);
                bus_write_enable = (op_reg == WRITE);
                grant_valid      = 1'b1;
            end
            ACK: begin
                req_acknowledge = NUM_REQ'(1) << grant_id_reg;
            end
            default: ;
        endcase
    end

    assign grant_id           = grant_id_reg;
    assign bus_address_to_mem = addr_reg;
    assign bus_data_to_mem    = req_data_to_mem[grant_id_reg];
    assign req_data_from_mem  = bus_data_from_mem;

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Directed bench for dram_bus_arbiter: single read/write, read+write priority,
// contention, stale-level protection with a level ack, and reset mid-transaction.
module tb_dram_bus_arbiter;
    import dram_bus_arbiter_pkg::*;

    localparam int NUM_REQ = 2;

    logic                                           clock;
    logic                                           reset_n;
    logic [NUM_REQ-1:0][ADDR_W-1:0]                 req_address;
    logic [NUM_REQ-1:0][BLOCK_WORDS-1:0][WORD_W-1:0] req_data_to_mem;
    logic [NUM_REQ-1:0]                             req_read_enable;
    logic [NUM_REQ-1:0]                             req_write_enable;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]             req_data_from_mem;
    logic [NUM_REQ-1:0]                             req_acknowledge;
    logic [ADDR_W-1:0]                              bus_address_to_mem;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]             bus_data_to_mem;
    logic                                           bus_read_enable;
    logic                                           bus_write_enable;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]             bus_data_from_mem;
    logic                                           acknowledge_from_mem;
    logic                                           grant_valid;
    logic                                           grant_id;

    int checks = 0;
    int errors = 0;

    dram_bus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .req_address          (req_address),
        .req_data_to_mem      (req_data_to_mem),
        .req_read_enable      (req_read_enable),
        .req_write_enable     (req_write_enable),
        .req_data_from_mem    (req_data_from_mem),
        .req_acknowledge      (req_acknowledge),
        .bus_address_to_mem   (bus_address_to_mem),
        .bus_data_to_mem      (bus_data_to_mem),
        .bus_read_enable      (bus_read_enable),
        .bus_write_enable     (bus_write_enable),
        .bus_data_from_mem    (bus_data_from_mem),
        .acknowledge_from_mem (acknowledge_from_mem),
        .grant_valid          (grant_valid),
        .grant_id             (grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [BLOCK_WORDS-1:0][WORD_W-1:0] rd_block;
        logic [BLOCK_WORDS-1:0][WORD_W-1:0] wr_block;
        logic                               exp_id;
        logic [ADDR_W-1:0]                  exp_addr;

        rd_block = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
        wr_block = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};

        reset_n              = 1'b0;
        req_address          = '0;
        req_data_to_mem[0]   = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        req_data_to_mem[1]   = wr_block;
        req_read_enable      = '0;
        req_write_enable     = '0;
        bus_data_from_mem    = rd_block;
        acknowledge_from_mem = 1'b0;

        // Reset values
        #12;
        check("rst_grant_valid", 128'(grant_valid), 128'(0));
        check("rst_grant_id", 128'(grant_id), 128'(0));
        check("rst_bus_en", 128'({bus_read_enable, bus_write_enable}), 128'(0));
        check("rst_req_ack", 128'(req_acknowledge), 128'(0));
        check("rst_bus_addr", 128'(bus_address_to_mem), 128'(0));
        reset_n = 1'b1;
        step();
        $display("txn reset: checks=%0d errors=%0d", checks, errors);

        // Single read: icache @0x100, ack after 6 enabled cycles
        req_address[0]     = 32'h100;
        req_read_enable[0] = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            check("rd_en", 128'(bus_read_enable), 128'(1));
            check("rd_wr_en", 128'(bus_write_enable), 128'(0));
            check("rd_addr", 128'(bus_address_to_mem), 128'(32'h100));
            if (k == 6) acknowledge_from_mem = 1'b1;
            step();
        end
        check("rd_en_after", 128'(bus_read_enable), 128'(0));
        check("rd_ack", 128'(req_acknowledge), 128'(2'b01));
        check("rd_data", 128'(req_data_from_mem), 128'(rd_block));
        acknowledge_from_mem = 1'b0;
        step();
        req_read_enable[0] = 1'b0;
        check("rd_ack_pulse", 128'(req_acknowledge), 128'(0));
        check("rd_idle", 128'(grant_valid), 128'(0));
        step();
        $display("txn single_read: checks=%0d errors=%0d", checks, errors);

        // Single write: dcache @0x200 with words A0..A3
        req_address[1]      = 32'h200;
        req_write_enable[1] = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) begin
            check("wr_en", 128'(bus_write_enable), 128'(1));
            check("wr_rd_en", 128'(bus_read_enable), 128'(0));
            check("wr_data", 128'(bus_data_to_mem), 128'(wr_block));
            check("wr_grant_id", 128'(grant_id), 128'(1));
            if (k == 3) acknowledge_from_mem = 1'b1;
            step();
        end
        check("wr_ack", 128'(req_acknowledge), 128'(2'b10));
        acknowledge_from_mem = 1'b0;
        step();
        req_write_enable[1] = 1'b0;
        check("wr_ack_pulse", 128'(req_acknowledge), 128'(0));
        step();
        $display("txn single_write: checks=%0d errors=%0d", checks, errors);

        // Read and write together from dcache: write wins
        req_address[1]      = 32'h240;
        req_read_enable[1]  = 1'b1;
        req_write_enable[1] = 1'b1;
        step();
        check("rw_wr_en", 128'(bus_write_enable), 128'(1));
        check("rw_rd_en", 128'(bus_read_enable), 128'(0));
        check("rw_addr", 128'(bus_address_to_mem), 128'(32'h240));
        acknowledge_from_mem = 1'b1;
        step();
        check("rw_ack", 128'(req_acknowledge), 128'(2'b10));
        acknowledge_from_mem = 1'b0;
        step();
        req_read_enable[1]  = 1'b0;
        req_write_enable[1] = 1'b0;
        step();
        $display("txn read_write: checks=%0d errors=%0d", checks, errors);

        // Contention: both read continuously; order 0,1,0,1 with two idle cycles between
        req_address[0]  = 32'h300;
        req_address[1]  = 32'h400;
        req_read_enable = 2'b11;
        step();
        for (int t = 0; t < 4; t++) begin
            exp_id   = t[0];
            exp_addr = exp_id ? 32'h400 : 32'h300;
            for (int k = 1; k <= 2; k++) begin
                check("ct_grant_valid", 128'(grant_valid), 128'(1));
                check("ct_grant_id", 128'(grant_id), 128'(exp_id));
                check("ct_addr", 128'(bus_address_to_mem), 128'(exp_addr));
                check("ct_excl", 128'({bus_read_enable, bus_write_enable}), 128'(2'b10));
                if (k == 2) acknowledge_from_mem = 1'b1;
                step();
            end
            check("ct_ack", 128'(req_acknowledge), 128'(NUM_REQ'(1) << exp_id));
            check("ct_gap1", 128'(grant_valid), 128'(0));
            acknowledge_from_mem = 1'b0;
            if (t == 3) req_read_enable = 2'b00;
            step();
            check("ct_gap2", 128'(grant_valid), 128'(0));
            check("ct_gap2_ack", 128'(req_acknowledge), 128'(0));
            step();
            $display("txn contention[%0d] id=%0d: checks=%0d errors=%0d", t, exp_id, checks, errors);
        end
        check("ct_end_idle", 128'(grant_valid), 128'(0));

        // Stale level: icache holds its enable one cycle past ack, memory ack is a level
        req_address[0]     = 32'h500;
        req_read_enable[0] = 1'b1;
        step();
        check("st_grant", 128'({grant_valid, grant_id}), 128'(2'b10));
        acknowledge_from_mem = 1'b1;
        step();
        check("st_ack", 128'(req_acknowledge), 128'(2'b01));
        step();
        check("st_ack_once", 128'(req_acknowledge), 128'(0));
        check("st_no_regrant1", 128'(grant_valid), 128'(0));
        req_read_enable[0] = 1'b0;
        step();
        check("st_no_regrant2", 128'(grant_valid), 128'(0));
        check("st_no_en", 128'({bus_read_enable, bus_write_enable}), 128'(0));
        check("st_ack_level", 128'(req_acknowledge), 128'(0));
        acknowledge_from_mem = 1'b0;
        step();
        $display("txn stale_level: checks=%0d errors=%0d", checks, errors);

        // Reset asserted during BUSY, then a fresh icache read completes
        req_address[0]     = 32'h600;
        req_read_enable[0] = 1'b1;
        step();
        step();
        check("rm_busy", 128'(bus_read_enable), 128'(1));
        reset_n = 1'b0;
        #1;
        check("rm_en", 128'({bus_read_enable, bus_write_enable}), 128'(0));
        check("rm_grant_valid", 128'(grant_valid), 128'(0));
        check("rm_ack", 128'(req_acknowledge), 128'(0));
        check("rm_addr", 128'(bus_address_to_mem), 128'(0));
        req_address[0] = 32'h700;
        #2;
        reset_n = 1'b1;
        step();
        check("rm_new_grant", 128'({grant_valid, grant_id}), 128'(2'b10));
        check("rm_new_addr", 128'(bus_address_to_mem), 128'(32'h700));
        check("rm_new_en", 128'(bus_read_enable), 128'(1));
        acknowledge_from_mem = 1'b1;
        step();
        check("rm_new_ack", 128'(req_acknowledge), 128'(2'b01));
        check("rm_new_data", 128'(req_data_from_mem), 128'(rd_block));
        acknowledge_from_mem = 1'b0;
        step();
        req_read_enable[0] = 1'b0;
        check("rm_new_done", 128'(req_acknowledge), 128'(0));
        step();
        $display("txn reset_mid: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
